// File: rtl/cm0_pkg.sv
// rtl/cm0_pkg.sv - shared ALU source-1 select codes and block-transfer sequencer states
package cm0_pkg;

  localparam logic [2:0] S1_RN       = 3'd0;
  localparam logic [2:0] S1_RM       = 3'd1;
  localparam logic [2:0] S1_NOT_RN   = 3'd2;
  localparam logic [2:0] S1_PC_ALIGN = 3'd3;
  localparam logic [2:0] S1_PC       = 3'd4;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_XFER = 2'd1,
    SEQ_WB   = 2'd2,
    SEQ_DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/lsb_find9.sv
// rtl/lsb_find9.sv - lowest-set-bit priority encoder over a 9-bit register list
module lsb_find9 (
  input  logic [8:0] bits,
  output logic [3:0] idx,
  output logic       none
);

  // Scanning downwards lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx  = 4'd0;
    none = (bits == 9'd0);
    for (int k = 8; k >= 0; k--) begin
      if (bits[k]) idx = 4'(k);
    end
  end

endmodule

// File: rtl/ldm_stm_seq.sv
// rtl/ldm_stm_seq.sv - LDMIA/STMIA/PUSH/POP sequencer: per-register address, memory handshake, base writeback
module ldm_stm_seq
  import cm0_pkg::*;
#(
  parameter bit DEC_ADDR = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_load,
  input  logic        dec,
  input  logic [2:0]  rn_idx,
  input  logic [3:0]  base_idx,
  input  logic [8:0]  reg_list,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic [2:0]  alu_src1_choose,
  output logic [31:0] alu_imm,
  output logic [3:0]  reg_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        rf_we
);

  seq_state_t  state, state_nx;
  logic [8:0]  list_q, list_rem;
  logic        is_load_q, dec_q;
  logic [3:0]  base_q;
  logic [2:0]  rn_q;
  logic [3:0]  n_q, i_q, n_start;
  logic [3:0]  lsb_idx;
  logic        lsb_none;
  logic [8:0]  lsb_onehot;
  logic        last_xfer;
  logic        base_in_list;
  logic [31:0] off_i, off_n;

  lsb_find9 u_lsb_find9 (
    .bits (list_rem),
    .idx  (lsb_idx),
    .none (lsb_none)
  );

  always_comb begin
    n_start = 4'd0;
    for (int k = 0; k < 9; k++) n_start = n_start + 4'(reg_list[k]);
  end

  assign lsb_onehot   = 9'd1 << lsb_idx;
  assign last_xfer    = ((list_rem & ~lsb_onehot) == 9'd0);
  // A high base index (SP) can never appear in the low-register list.
  assign base_in_list = !base_q[3] && list_q[rn_q];
  assign off_i        = {26'd0, i_q, 2'b00};
  assign off_n        = {26'd0, n_q, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEQ_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      list_q    <= 9'd0;
      list_rem  <= 9'd0;
      is_load_q <= 1'b0;
      dec_q     <= 1'b0;
      base_q    <= 4'd0;
      rn_q      <= 3'd0;
      n_q       <= 4'd0;
      i_q       <= 4'd0;
    end else if (state == SEQ_IDLE && start) begin
      list_q    <= reg_list;
      list_rem  <= reg_list;
      is_load_q <= is_load;
      dec_q     <= dec | DEC_ADDR;
      base_q    <= base_idx;
      rn_q      <= rn_idx;
      n_q       <= n_start;
      i_q       <= 4'd0;
    end else if (state == SEQ_XFER && mem_ack) begin
      list_rem  <= list_rem & ~lsb_onehot;
      i_q       <= i_q + 4'd1;
    end
  end

  always_comb begin
    state_nx        = state;
    busy            = 1'b0;
    done            = 1'b0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    rf_we           = 1'b0;
    alu_imm         = 32'd0;
    reg_sel         = 4'd0;
    alu_src1_choose = S1_RN;
    case (state)
      SEQ_IDLE: begin
        if (start) state_nx = (n_start != 4'd0) ? SEQ_XFER : SEQ_DONE;
      end
      SEQ_XFER: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = !is_load_q;
        reg_sel = (lsb_idx == 4'd8) ? (is_load_q ? 4'd15 : 4'd14) : lsb_idx;
        alu_imm = dec_q ? (off_i - off_n) : off_i;
        rf_we   = is_load_q & mem_ack;
        if (lsb_none || (mem_ack && last_xfer)) state_nx = SEQ_WB;
      end
      SEQ_WB: begin
        busy     = 1'b1;
        reg_sel  = base_q;
        alu_imm  = dec_q ? (32'd0 - off_n) : off_n;
        rf_we    = !(is_load_q && base_in_list);
        state_nx = SEQ_DONE;
      end
      SEQ_DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = SEQ_IDLE;
      end
      default: state_nx = SEQ_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// tb/tb_ldm_stm_seq.sv - scoreboard bench for the block-transfer sequencer
module tb_ldm_stm_seq;

  typedef struct {
    int          kind;   // 0 transfer, 1 writeback, 2 done
    logic [3:0]  rsel;
    logic [31:0] imm;
    logic        we;
    logic        rfwe;
    int          lat;
  } exp_t;

  logic        clk, rst_n, start, is_load, dec, mem_ack;
  logic [2:0]  rn_idx;
  logic [3:0]  base_idx;
  logic [8:0]  reg_list;
  logic        busy, done, mem_req, mem_we, rf_we;
  logic [2:0]  alu_src1_choose;
  logic [31:0] alu_imm;
  logic [3:0]  reg_sel;

  exp_t exp_q[$];
  int   n_pass = 0, n_total = 0;
  int   cyc = 0, start_cyc = 0, wait_states = 0, wcnt = 0;
  bit   done_flag = 0;

  ldm_stm_seq #(.DEC_ADDR(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load), .dec(dec),
    .rn_idx(rn_idx), .base_idx(base_idx), .reg_list(reg_list), .mem_ack(mem_ack),
    .busy(busy), .done(done), .alu_src1_choose(alu_src1_choose), .alu_imm(alu_imm),
    .reg_sel(reg_sel), .mem_req(mem_req), .mem_we(mem_we), .rf_we(rf_we)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push_x(input logic [3:0] r, input logic [31:0] imm, input logic we, input logic rfwe);
    exp_q.push_back('{kind: 0, rsel: r, imm: imm, we: we, rfwe: rfwe, lat: 0});
  endtask

  task automatic push_wb(input logic [3:0] r, input logic [31:0] imm, input logic rfwe);
    exp_q.push_back('{kind: 1, rsel: r, imm: imm, we: 1'b0, rfwe: rfwe, lat: 0});
  endtask

  task automatic push_done(input int lat);
    exp_q.push_back('{kind: 2, rsel: 4'd0, imm: 32'd0, we: 1'b0, rfwe: 1'b0, lat: lat});
  endtask

  // Memory model: acknowledges each request after wait_states idle cycles.
  always @(posedge clk) begin
    #1;
    if (rst_n && mem_req) begin
      if (wcnt == wait_states) begin
        mem_ack = 1'b1;
        wcnt = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (mem_req) begin
        if (exp_q.size() == 0) chk("unexpected_xfer", 32'd1, 32'd0);
        else begin
          e = exp_q[0];
          chk("xfer_kind", 32'(e.kind), 32'd0);
          chk("xfer_reg_sel", {28'd0, reg_sel}, {28'd0, e.rsel});
          chk("xfer_alu_imm", alu_imm, e.imm);
          chk("xfer_mem_we", {31'd0, mem_we}, {31'd0, e.we});
          chk("xfer_busy", {31'd0, busy}, 32'd1);
          if (mem_ack) begin
            chk("xfer_rf_we_ack", {31'd0, rf_we}, {31'd0, e.rfwe});
            void'(exp_q.pop_front());
          end else begin
            chk("xfer_rf_we_wait", {31'd0, rf_we}, 32'd0);
          end
        end
      end else if (busy && !done) begin
        if (exp_q.size() == 0) chk("unexpected_wb", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("wb_kind", 32'(e.kind), 32'd1);
          chk("wb_reg_sel", {28'd0, reg_sel}, {28'd0, e.rsel});
          chk("wb_alu_imm", alu_imm, e.imm);
          chk("wb_rf_we", {31'd0, rf_we}, {31'd0, e.rfwe});
        end
      end else if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("done_kind", 32'(e.kind), 32'd2);
          chk("done_latency", 32'(cyc - start_cyc), 32'(e.lat));
          chk("done_busy", {31'd0, busy}, 32'd1);
          chk("done_rf_we", {31'd0, rf_we}, 32'd0);
        end
        done_flag = 1'b1;
      end
    end
  end

  task automatic launch(input logic il, input logic dc, input logic [2:0] rn,
                        input logic [3:0] bi, input logic [8:0] lst, input int w);
    @(posedge clk);
    #1;
    wait_states = w;
    is_load = il; dec = dc; rn_idx = rn; base_idx = bi; reg_list = lst;
    start = 1'b1;
    start_cyc = cyc;
    done_flag = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 100 && !done_flag; c++) @(posedge clk);
    if (!done_flag) chk("done_timeout", 32'd1, 32'd0);
    @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; is_load = 1'b0; dec = 1'b0; mem_ack = 1'b0;
    rn_idx = 3'd0; base_idx = 4'd0; reg_list = 9'd0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_alu_imm", alu_imm, 32'd0);
    chk("rst_reg_sel", {28'd0, reg_sel}, 32'd0);
    chk("rst_src1", {29'd0, alu_src1_choose}, 32'd0);
    rst_n = 1'b1;

    // STM R1!,{R0,R2,R5}, zero-wait, plus a start pulse while busy
    push_x(4'd0, 32'd0, 1'b1, 1'b0);
    push_x(4'd2, 32'd4, 1'b1, 1'b0);
    push_x(4'd5, 32'd8, 1'b1, 1'b0);
    push_wb(4'd1, 32'd12, 1'b1);
    push_done(5);
    launch(1'b0, 1'b0, 3'd1, 4'd1, 9'b0_0010_0101, 0);
    chk("src1_busy", {29'd0, alu_src1_choose}, 32'd0);
    start = 1'b1; reg_list = 9'h0FF;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();

    // PUSH {R4,LR}
    push_x(4'd4, 32'hFFFF_FFF8, 1'b1, 1'b0);
    push_x(4'd14, 32'hFFFF_FFFC, 1'b1, 1'b0);
    push_wb(4'd13, 32'hFFFF_FFF8, 1'b1);
    push_done(4);
    launch(1'b0, 1'b1, 3'd0, 4'd13, 9'h110, 0);
    wait_done();

    // POP {R0,PC} with two wait states per transfer
    push_x(4'd0, 32'd0, 1'b0, 1'b1);
    push_x(4'd15, 32'd4, 1'b0, 1'b1);
    push_wb(4'd13, 32'd8, 1'b1);
    push_done(8);
    launch(1'b1, 1'b0, 3'd0, 4'd13, 9'h101, 2);
    wait_done();

    // LDM R3,{R1,R3}: loaded base suppresses writeback
    push_x(4'd1, 32'd0, 1'b0, 1'b1);
    push_x(4'd3, 32'd4, 1'b0, 1'b1);
    push_wb(4'd3, 32'd8, 1'b0);
    push_done(4);
    launch(1'b1, 1'b0, 3'd3, 4'd3, 9'h00A, 0);
    wait_done();

    // Empty list
    push_done(1);
    launch(1'b1, 1'b0, 3'd2, 4'd2, 9'h000, 0);
    wait_done();

    // Reset during the second transfer's wait state
    push_x(4'd0, 32'd0, 1'b1, 1'b0);
    push_x(4'd1, 32'd4, 1'b1, 1'b0);
    launch(1'b0, 1'b0, 3'd4, 4'd4, 9'h007, 2);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Normal run after reset: STM R2!,{R7}
    push_x(4'd7, 32'd0, 1'b1, 1'b0);
    push_wb(4'd2, 32'd4, 1'b1);
    push_done(3);
    launch(1'b0, 1'b0, 3'd2, 4'd2, 9'h080, 0);
    wait_done();

    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
